// File: rtl/mips_regfile_loader_pkg.sv
// Shared types and default sizing for the MIPS register file loader.
package mips_regfile_loader_pkg;

  localparam int unsigned NumRegsDefault = 32;
  localparam int unsigned RegWDefault    = 5;
  localparam int unsigned DataWDefault   = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDumpRd,
    StDumpWait,
    StFinish
  } state_e;

endpackage

// File: rtl/mips_reg_index_counter.sv
// Register index counter: clear, increment with wrap at NUM_REGS, last-index flag.
module mips_reg_index_counter #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [REG_W-1:0] idx,
  output logic             last
);

  logic [REG_W-1:0] idx_q, idx_d;

  assign last = (idx_q == REG_W'(NUM_REGS - 1));
  assign idx  = idx_q;

  // Next index: clear has priority, increment wraps back to zero after the last register
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  // Index register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mips_regfile_loader.sv
// Bulk loader for the MIPS register file, fed by a valid/ready word stream.
// Define MIPS_REGDUMP_EN to add the dump path that streams the file back out via read port 1.
module mips_regfile_loader
  import mips_regfile_loader_pkg::*;
#(
  parameter int unsigned NUM_REGS  = NumRegsDefault,
  parameter int unsigned REG_W     = RegWDefault,
  parameter int unsigned DATA_W    = DataWDefault,
  parameter bit          SKIP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [REG_W-1:0]  write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              signal_reg_write,
  output logic              busy,
  output logic              done,
  input  logic              dump_start,
  output logic [REG_W-1:0]  read_reg_1,
  input  logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e            state_q, state_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              cnt_clr, cnt_inc;
  logic [REG_W-1:0]  idx;
  logic              idx_last;

`ifdef MIPS_REGDUMP_EN
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
`endif

  mips_reg_index_counter #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .idx   (idx),
    .last  (idx_last)
  );

  assign in_ready         = (state_q == StLoad);
  assign busy             = (state_q != StIdle);
  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;
  assign signal_reg_write = we_q;
  assign done             = done_q;

`ifdef MIPS_REGDUMP_EN
  assign read_reg_1 = (state_q == StDumpRd) ? idx : '0;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
`else
  assign read_reg_1 = '0;
  assign out_data   = '0;
  assign out_valid  = 1'b0;

  logic unused_dump;
  assign unused_dump = ^{dump_start, out_ready, read_data_1};
`endif

  // Sequencer: next state, write-port strobe and dump output staging
  always_comb begin
    state_d      = state_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    we_d         = 1'b0;
    done_d       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
`ifdef MIPS_REGDUMP_EN
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
`endif
    unique case (state_q)
      StIdle: begin
        // start wins over a simultaneous dump_start
        if (start) begin
          state_d = StLoad;
          cnt_clr = 1'b1;
`ifdef MIPS_REGDUMP_EN
        end else if (dump_start) begin
          state_d = StDumpRd;
          cnt_clr = 1'b1;
`endif
        end
      end
      StLoad: begin
        if (in_valid) begin
          write_reg_d  = idx;
          write_data_d = in_data;
          // $zero's word is consumed but never written
          we_d         = !(SKIP_ZERO && (idx == '0));
          cnt_inc      = 1'b1;
          if (idx_last) begin
            state_d = StFinish;
          end
        end
      end
`ifdef MIPS_REGDUMP_EN
      StDumpRd: begin
        out_data_d  = read_data_1;
        out_valid_d = 1'b1;
        state_d     = StDumpWait;
      end
      StDumpWait: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_inc     = 1'b1;
          state_d     = idx_last ? StFinish : StDumpRd;
        end
      end
`endif
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      write_reg_q  <= '0;
      write_data_q <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
`ifdef MIPS_REGDUMP_EN
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      we_q         <= we_d;
      done_q       <= done_d;
`ifdef MIPS_REGDUMP_EN
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_regfile_loader.sv
// Directed/randomized bench for mips_regfile_loader with a behavioural register file model.
module tb_mips_regfile_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write;
  logic        busy;
  logic        done;
  logic        dump_start = 1'b0;
  logic [4:0]  read_reg_1;
  logic [31:0] read_data_1;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int preset_mode = 0;

  logic [31:0] rf [32];
  logic [31:0] words [32];

  always #5 clk = ~clk;

  mips_regfile_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .busy             (busy),
    .done             (done),
    .dump_start       (dump_start),
    .read_reg_1       (read_reg_1),
    .read_data_1      (read_data_1),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  // Register file attached to the DUT ports (not reset; preset on demand)
  always @(posedge clk) begin
    if (preset_mode == 1) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hffff_ffff;
    end else if (preset_mode == 2) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i * 3);
    end else if (signal_reg_write) begin
      rf[write_reg] <= write_data;
    end
  end
  assign read_data_1 = rf[read_reg_1];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_preset(input int mode);
    preset_mode = mode;
    @(posedge clk); #1;
    preset_mode = 0;
  endtask

  // Feed n_words words; vmode 0=valid held, 1=toggled, 2=random. restart_at pulses start mid-load.
  task automatic run_load(input int n_words, input int vmode, input bit both, input int restart_at);
    int k = 0;
    int cyc = 0;
    bit acc;
    bit exp_we = 1'b0;
    logic [31:0] exp_wr = '0;
    logic [31:0] exp_wd = '0;
    start = 1'b1;
    dump_start = both;
    @(posedge clk); #1;
    start = 1'b0;
    dump_start = 1'b0;
    while (k < n_words && cyc < 400) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = words[k];
      start = (cyc == restart_at);
      @(negedge clk);
      check("load_in_ready", 32'(in_ready), 32'd1);
      check("load_busy", 32'(busy), 32'd1);
      check("load_strobe", 32'(signal_reg_write), 32'(exp_we));
      if (exp_we) begin
        check("load_write_reg", 32'(write_reg), exp_wr);
        check("load_write_data", write_data, exp_wd);
      end
      acc = in_valid;
      @(posedge clk); #1;
      exp_we = acc && (k != 0);
      exp_wr = 32'(k);
      exp_wd = words[k];
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (cyc >= 400) check("load_timeout", 32'(k), 32'(n_words));
    if (n_words == 32) begin
      @(negedge clk);
      check("last_strobe", 32'(signal_reg_write), 32'd1);
      check("last_write_reg", 32'(write_reg), 32'd31);
      check("last_write_data", write_data, words[31]);
      check("finish_done_low", 32'(done), 32'd0);
      check("finish_busy", 32'(busy), 32'd1);
      check("finish_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy_low", 32'(busy), 32'd0);
      check("done_no_strobe", 32'(signal_reg_write), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic check_rf_loaded();
    check("rf_zero_untouched", rf[0], 32'hffff_ffff);
    for (int i = 1; i < 32; i++) check("rf_value", rf[i], words[i]);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobe", 32'(signal_reg_write), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_read_reg_1", 32'(read_reg_1), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: full load, valid held, words 0x1000+i
    do_preset(1);
    for (int i = 0; i < 32; i++) words[i] = 32'h1000 + 32'(i);
    run_load(32, 0, 1'b0, -1);
    check_rf_loaded();

    // 2: valid toggled, random data
    do_preset(1);
    for (int i = 0; i < 32; i++) words[i] = $urandom();
    run_load(32, 1, 1'b0, -1);
    check_rf_loaded();

    // 3: reset after 10 accepted words, then a fresh load from idx0
    do_preset(1);
    for (int i = 0; i < 32; i++) words[i] = $urandom();
    run_load(10, 0, 1'b0, -1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_strobe", 32'(signal_reg_write), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 1; i < 10; i++) check("abort_rf_kept", rf[i], words[i]);
    check("abort_rf_unwritten", rf[10], 32'hffff_ffff);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_preset(1);
    for (int i = 0; i < 32; i++) words[i] = $urandom();
    run_load(32, 2, 1'b0, -1);
    check_rf_loaded();

    // 4: start+dump_start together selects load; a second start mid-load is ignored
    do_preset(1);
    for (int i = 0; i < 32; i++) words[i] = $urandom();
    run_load(32, 2, 1'b1, 5);
    check_rf_loaded();

`ifdef MIPS_REGDUMP_EN
    // 5: dump with 5 stall cycles per word
    do_preset(2);
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    for (int j = 0; j < 32; j++) begin
      int w = 0;
      @(negedge clk);
      while (!out_valid && w < 4) begin
        @(posedge clk); #1;
        @(negedge clk);
        w++;
      end
      check("dump_valid", 32'(out_valid), 32'd1);
      for (int s = 0; s < 5; s++) begin
        check("dump_stall_data", out_data, 32'(j * 3));
        check("dump_stall_valid", 32'(out_valid), 32'd1);
        check("dump_stall_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
      end
      check("dump_data", out_data, 32'(j * 3));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("dump_valid_drop", 32'(out_valid), 32'd0);
      check("dump_done_early", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("dump_done", 32'(done), 32'd1);
    check("dump_busy_low", 32'(busy), 32'd0);
    @(posedge clk); #1;
`else
    // 6: dump disabled, dump_start has no effect
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("nodump_busy", 32'(busy), 32'd0);
      check("nodump_out_valid", 32'(out_valid), 32'd0);
      check("nodump_in_ready", 32'(in_ready), 32'd0);
      check("nodump_read_reg_1", 32'(read_reg_1), 32'd0);
      check("nodump_out_data", out_data, 32'd0);
      @(posedge clk); #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
